// File: rtl/williams2_nvram_pkg.sv
// Shared constants and types for the Williams 2 CMOS RAM arbiter.
package williams2_nvram_pkg;

  localparam int NV_AW = 10;
  localparam int NV_DW = 4;
  localparam logic [3:0] CLEAR_VAL = 4'h0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PAUSE,
    ST_LOAD,
    ST_SAVE,
    ST_CLEAR,
    ST_RELEASE
  } nv_state_e;

  // Which owner the PAUSE state is acquiring the RAM for.
  typedef enum logic [1:0] {
    TGT_LOAD,
    TGT_SAVE,
    TGT_CLEAR
  } nv_tgt_e;

endpackage

// File: rtl/williams2_nvram_arb.sv
// CMOS RAM arbiter: CPU owns the RAM in IDLE; HPS load/save and the clear
// sequencer take it only after the CPU acknowledges a pause.
module williams2_nvram_arb
  import williams2_nvram_pkg::*;
#(
  parameter int AW = williams2_nvram_pkg::NV_AW,
  parameter int DW = williams2_nvram_pkg::NV_DW,
  parameter logic [DW-1:0] CLEAR_VAL = williams2_nvram_pkg::CLEAR_VAL
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          cpu_cs,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  output logic [DW-1:0] cpu_dout,
  output logic          cpu_pause,
  input  logic          pause_ack,
  input  logic          hps_load,
  input  logic          hps_save,
  input  logic [AW-1:0] hps_addr,
  input  logic          hps_wr,
  input  logic [7:0]    hps_din,
  input  logic          hps_rd,
  output logic [7:0]    hps_dout,
  output logic          hps_wait,
  input  logic          clear_req,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          busy,
  output logic          dirty,
  output nv_state_e     dbg_state
);

  nv_state_e     state_q, state_d;
  nv_tgt_e       tgt_q, tgt_d;
  logic          clr_pend_q, clr_pend_d;
  logic          clr_req_q;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          dirty_q, dirty_d;

  logic          ld_we_q;
  logic [AW-1:0] ld_addr_q;
  logic [DW-1:0] ld_din_q;

  logic          rd_p1_q, rd_p2_q;
  logic [AW-1:0] rd_addr_q;
  logic [7:0]    hps_dout_q;

  logic          clear_edge;
  logic          req_live;
  logic          rd_accept;
  logic          unused_hps_din;

  assign unused_hps_din = ^hps_din[7:DW];

  assign clear_edge = clear_req & ~clr_req_q;

  // HPS read handshake: a strobe is taken only while hps_wait is low; hps_wait
  // then stays high for two cycles and hps_dout is valid when it falls.
  assign rd_accept  = (state_q == ST_SAVE) && hps_rd && !hps_wait;
  assign hps_wait   = rd_p1_q | rd_p2_q;
  assign hps_dout   = hps_dout_q;

  assign cpu_dout   = ram_dout;
  assign busy       = (state_q != ST_IDLE);
  assign dirty      = dirty_q;
  assign dbg_state  = state_q;

  always_comb begin
    req_live = 1'b1;
    case (tgt_q)
      TGT_LOAD: req_live = hps_load;
      TGT_SAVE: req_live = hps_save;
      default:  req_live = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    clr_cnt_d  = clr_cnt_q;
    dirty_d    = dirty_q;
    clr_pend_d = clr_pend_q | (clear_edge & (state_q != ST_CLEAR));
    cpu_pause  = 1'b0;
    ram_addr   = cpu_addr;
    ram_din    = cpu_din;
    ram_we     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ram_we = cpu_cs & cpu_we;
        if (cpu_cs && cpu_we) dirty_d = 1'b1;
        if (hps_load) begin
          tgt_d   = TGT_LOAD;
          state_d = ST_PAUSE;
        end else if (hps_save) begin
          tgt_d   = TGT_SAVE;
          state_d = ST_PAUSE;
        end else if (clr_pend_d) begin
          tgt_d   = TGT_CLEAR;
          state_d = ST_PAUSE;
        end
      end

      ST_PAUSE: begin
        cpu_pause = 1'b1;
        if (!req_live) begin
          state_d = ST_RELEASE;
        end else if (pause_ack) begin
          case (tgt_q)
            TGT_LOAD: state_d = ST_LOAD;
            TGT_SAVE: state_d = ST_SAVE;
            default: begin
              state_d    = ST_CLEAR;
              clr_pend_d = 1'b0;
              clr_cnt_d  = '0;
            end
          endcase
        end
      end

      ST_LOAD: begin
        cpu_pause = 1'b1;
        ram_addr  = ld_addr_q;
        ram_din   = ld_din_q;
        ram_we    = ld_we_q;
        if (!hps_load) begin
          dirty_d = 1'b0;
          state_d = ST_RELEASE;
        end
      end

      ST_SAVE: begin
        cpu_pause = 1'b1;
        ram_addr  = rd_addr_q;
        if (!hps_save) begin
          dirty_d = 1'b0;
          state_d = ST_RELEASE;
        end
      end

      ST_CLEAR: begin
        cpu_pause = 1'b1;
        ram_addr  = clr_cnt_q;
        ram_din   = CLEAR_VAL;
        ram_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + {{(AW-1){1'b0}}, 1'b1};
        // The last cell ends the sweep; the counter never restarts by itself.
        if (clr_cnt_q == {AW{1'b1}}) begin
          clr_cnt_d = '0;
          dirty_d   = 1'b1;
          state_d   = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        if (!pause_ack) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      tgt_q      <= TGT_LOAD;
      clr_pend_q <= 1'b0;
      clr_req_q  <= 1'b0;
      clr_cnt_q  <= '0;
      dirty_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      clr_pend_q <= clr_pend_d;
      clr_req_q  <= clear_req;
      clr_cnt_q  <= clr_cnt_d;
      dirty_q    <= dirty_d;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ld_we_q   <= 1'b0;
      ld_addr_q <= '0;
      ld_din_q  <= '0;
    end else begin
      ld_we_q <= (state_q == ST_LOAD) && hps_wr;
      if (hps_wr) begin
        ld_addr_q <= hps_addr;
        ld_din_q  <= hps_din[DW-1:0];
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rd_p1_q    <= 1'b0;
      rd_p2_q    <= 1'b0;
      rd_addr_q  <= '0;
      hps_dout_q <= 8'hFF;
    end else begin
      rd_p1_q <= rd_accept;
      rd_p2_q <= rd_p1_q;
      if (rd_accept) rd_addr_q <= hps_addr;
      if (rd_p2_q) hps_dout_q <= {{(8-DW){1'b1}}, ram_dout};
    end
  end

endmodule

// File: tb/tb_williams2_nvram_arb.sv
// Directed bench for williams2_nvram_arb with a behavioural 1K x 4 RAM.
module tb_williams2_nvram_arb;
  import williams2_nvram_pkg::*;

  localparam int AW = 10;
  localparam int DW = 4;

  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b0;
  logic          cpu_cs = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_din = '0;
  logic [DW-1:0] cpu_dout;
  logic          cpu_pause;
  logic          pause_ack = 1'b0;
  logic          hps_load = 1'b0, hps_save = 1'b0;
  logic [AW-1:0] hps_addr = '0;
  logic          hps_wr = 1'b0, hps_rd = 1'b0;
  logic [7:0]    hps_din = '0;
  logic [7:0]    hps_dout;
  logic          hps_wait;
  logic          clear_req = 1'b0;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout = '0;
  logic          busy, dirty;
  nv_state_e     dbg_state;

  williams2_nvram_arb dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_pause(cpu_pause), .pause_ack(pause_ack),
    .hps_load(hps_load), .hps_save(hps_save), .hps_addr(hps_addr),
    .hps_wr(hps_wr), .hps_din(hps_din), .hps_rd(hps_rd), .hps_dout(hps_dout),
    .hps_wait(hps_wait), .clear_req(clear_req),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
    .busy(busy), .dirty(dirty), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_sys = ~clk_sys;

  // ---------------- RAM model ----------------
  logic [DW-1:0] mem [0:1023];
  initial for (int i = 0; i < 1024; i++) mem[i] = '0;
  always @(posedge clk_sys) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_miss = 0;
  int ack_delay = 3;
  logic [AW+DW-1:0] exp_q[$];
  logic [7:0]       exp_rd_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // CPU model: acknowledges a pause after ack_delay cycles, drops it on release.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk_sys);
      #1;
      if (cpu_pause) begin
        if (cnt >= ack_delay) pause_ack = 1'b1;
        else cnt++;
      end else begin
        pause_ack = 1'b0;
        cnt = 0;
      end
    end
  end

  // Monitor: every RAM write and every completed HPS read is checked in order.
  initial begin
    logic             wait_prev;
    int               wait_len;
    logic [AW+DW-1:0] e;
    logic [7:0]       r;
    wait_prev = 1'b0;
    wait_len  = 0;
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        wait_prev = 1'b0;
        wait_len  = 0;
      end else begin
        if (ram_we) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_ram_write: got addr %0h data %0h expected none", ram_addr, ram_din);
          end else begin
            e = exp_q.pop_front();
            chk("ram_write", {ram_addr, ram_din}, e);
          end
        end
        if (hps_wait) begin
          wait_len++;
        end else if (wait_prev) begin
          chk("hps_wait_len", wait_len, 2);
          if (exp_rd_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_hps_read: got %0h expected none", hps_dout);
          end else begin
            r = exp_rd_q.pop_front();
            chk("hps_dout", hps_dout, r);
          end
          wait_len = 0;
        end
        wait_prev = hps_wait;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_din = d;
    exp_q.push_back({a, d});
    tick();
    cpu_cs = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic wait_owner(input string name);
    for (int i = 0; i < 200 && !pause_ack; i++) tick();
    chk(name, pause_ack, 1);
    tick();
  endtask

  task automatic wait_idle(input string name, input int limit);
    for (int i = 0; i < limit && busy; i++) tick();
    chk(name, busy, 0);
  endtask

  task automatic hps_read(input logic [AW-1:0] a, input logic [7:0] exp);
    hps_addr = a; hps_rd = 1'b1;
    exp_rd_q.push_back(exp);
    tick();
    hps_rd = 1'b0;
    ticks(4);
  endtask

  function automatic int count_not(input logic [DW-1:0] v);
    int bad;
    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== v) bad++;
    return bad;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    ticks(3);
    reset_n = 1'b1;
    tick();
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_pause", cpu_pause, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dirty", dirty, 0);
    chk("rst_wait", hps_wait, 0);
    chk("rst_hps_dout", hps_dout, 8'hFF);
    chk("rst_ram_we", ram_we, 0);

    // CPU write passes straight through in IDLE
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h123; cpu_din = 4'hA;
    exp_q.push_back({10'h123, 4'hA});
    #1;
    chk("cpu_we_pass", ram_we, 1);
    chk("cpu_addr_pass", ram_addr, 10'h123);
    chk("cpu_din_pass", ram_din, 4'hA);
    chk("dirty_before_edge", dirty, 0);
    tick();
    cpu_cs = 1'b0; cpu_we = 1'b0;
    chk("dirty_after_write", dirty, 1);
    cpu_write(10'h010, 4'h5);

    // HPS strobes outside LOAD/SAVE are dropped
    hps_addr = 10'h3FF; hps_din = 8'hAB; hps_wr = 1'b1; hps_rd = 1'b1;
    tick();
    hps_wr = 1'b0; hps_rd = 1'b0;
    ticks(3);
    chk("idle_strobe_wait", hps_wait, 0);

    // SAVE
    ack_delay = 5;
    hps_save = 1'b1;
    tick();
    chk("save_pause", cpu_pause, 1);
    chk("save_busy", busy, 1);
    wait_owner("save_ack_timeout");
    chk("save_wait_idle", hps_wait, 0);
    hps_addr = 10'h010; hps_rd = 1'b1;
    exp_rd_q.push_back(8'hF5);
    tick();
    hps_addr = 10'h123;
    tick();
    hps_rd = 1'b0;
    ticks(4);
    hps_read(10'h123, 8'hFA);
    hps_save = 1'b0;
    tick();
    chk("save_end_pause", cpu_pause, 0);
    chk("save_end_dirty", dirty, 0);
    chk("save_end_busy", busy, 1);
    wait_idle("save_release", 50);

    // LOAD with CPU writes attempted throughout
    cpu_write(10'h200, 4'h9);
    chk("dirty_pre_load", dirty, 1);
    ack_delay = 2;
    hps_load = 1'b1;
    wait_owner("load_ack_timeout");
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h005; cpu_din = 4'h7;
    for (int i = 0; i < 1024; i++) begin
      hps_wr = 1'b1; hps_addr = AW'(i); hps_din = 8'h3C;
      exp_q.push_back({AW'(i), 4'hC});
      tick();
      if (hps_wait) chk("load_wait_low", hps_wait, 0);
    end
    hps_wr = 1'b0; cpu_cs = 1'b0; cpu_we = 1'b0;
    ticks(2);
    hps_load = 1'b0;
    tick();
    chk("load_end_dirty", dirty, 0);
    wait_idle("load_release", 50);
    chk("load_image_bad_cells", count_not(4'hC), 0);

    // LOAD and clear edge together: LOAD first, then CLEAR with no new edge
    hps_load = 1'b1; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    wait_owner("load2_ack_timeout");
    for (int i = 0; i < 4; i++) begin
      hps_wr = 1'b1; hps_addr = AW'(i); hps_din = 8'h37;
      exp_q.push_back({AW'(i), 4'h7});
      tick();
    end
    hps_wr = 1'b0;
    ticks(2);
    hps_load = 1'b0;
    for (int i = 0; i < 1024; i++) exp_q.push_back({AW'(i), 4'h0});
    wait_idle("load2_release", 50);
    tick();
    chk("clear_follows_load", busy, 1);
    wait_idle("pending_clear_done", 3000);
    chk("clear_sets_dirty", dirty, 1);
    chk("clear_image_bad_cells", count_not(4'h0), 0);

    // Standalone clear from a single pulse
    mem[10'h2AA] = 4'hF;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    chk("clear_busy", busy, 1);
    chk("clear_pause", cpu_pause, 1);
    for (int i = 0; i < 1024; i++) exp_q.push_back({AW'(i), 4'h0});
    wait_idle("clear_done", 3000);
    chk("clear2_image_bad_cells", count_not(4'h0), 0);

    // Reset in the middle of a clear
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 500; i++) exp_q.push_back({AW'(i), 4'h0});
    for (int i = 0; i < 3000 && !(ram_we && ram_addr == 10'd500); i++) tick();
    chk("clear_reach_500", {ram_we, ram_addr}, {1'b1, 10'd500});
    reset_n = 1'b0;
    #1;
    chk("midrst_pause", cpu_pause, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ram_we", ram_we, 0);
    ticks(3);
    reset_n = 1'b1;
    ticks(50);
    chk("postrst_busy", busy, 0);
    chk("postrst_state", dbg_state, ST_IDLE);
    chk("postrst_dirty", dirty, 0);

    chk("scoreboard_drained", exp_q.size() + exp_rd_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/williams2_nvram_arb.md
Name: williams2_nvram_arb

Overview:
- Arbitrates the game's battery-backed CMOS RAM (1K x 4) between the 6809 CPU and the HPS high-score load/save path.
- Also runs the "High Score Reset" clear sequence.
- Sits between the emu top level (ioctl, OSD status) and the williams2 core.
- Stalls the CPU via a pause handshake before the HPS or the clear sequencer takes the RAM, and tracks unsaved CPU writes.

Parameters:
- AW, 10, RAM address width (1024 nibbles).
- DW, 4, RAM data width.
- CLEAR_VAL, 4'h0, value written to every cell by the clear sequence.

Ports:
- clk_sys  in  1  system clock (12 MHz domain).
- reset_n  in  1  asynchronous, active-low reset.
- cpu_cs  in  1  CPU selects CMOS RAM this cycle.
- cpu_we  in  1  CPU write strobe, qualified by cpu_cs.
- cpu_addr  in  AW  CPU address.
- cpu_din  in  DW  CPU write data.
- cpu_dout  out  DW  read data to CPU (ram_dout passthrough).
- cpu_pause  out  1  request CPU halt.
- pause_ack  in  1  CPU halted at bus boundary.
- hps_load  in  1  HPS download of NVRAM image active (level).
- hps_save  in  1  HPS upload of NVRAM image active (level).
- hps_addr  in  AW  HPS byte index.
- hps_wr  in  1  one-cycle HPS write strobe.
- hps_din  in  8  HPS write byte; bits [3:0] used.
- hps_rd  in  1  one-cycle HPS read strobe.
- hps_dout  out  8  {4'hF, nibble}.
- hps_wait  out  1  HPS must hold off the next strobe.
- clear_req  in  1  rising edge starts the clear sequence.
- ram_addr  out  AW  RAM address.
- ram_we  out  1  RAM write enable.
- ram_din  out  DW  RAM write data.
- ram_dout  in  DW  RAM read data, 1-cycle latency.
- busy  out  1  arbiter not in IDLE.
- dirty  out  1  CPU has written since the last completed save or load.

Behaviour:
- Reset values: state IDLE; cpu_pause, ram_we, hps_wait, busy, dirty = 0; hps_dout = 8'hFF; clear counter 0.
- IDLE: CPU owns the RAM combinationally.
  - ram_addr = cpu_addr; ram_din = cpu_din; ram_we = cpu_cs & cpu_we.
  - Any CPU write sets dirty.
- Request priority when several arrive in the same cycle: hps_load > hps_save > clear edge. Lower-priority requests stay pending (clear edge latched) and are served after RELEASE.
- PAUSE: cpu_pause = 1, busy = 1; wait for pause_ack = 1.
  - If the request drops before the ack, go to RELEASE.
  - From this state onward, CPU writes are ignored (ram_we driven by the owner).
- LOAD (hps_load high, ack seen):
  - hps_wr at cycle t gives ram_we = 1 at t+1 with registered addr/data (hps_din[3:0]).
  - hps_wait = 0 throughout.
  - hps_load falling: clear dirty, go to RELEASE.
- SAVE:
  - hps_rd at t: ram_addr <= hps_addr at t+1; hps_dout registered at t+2.
  - hps_wait high during t+1..t+2.
  - An hps_rd while hps_wait is high is ignored.
  - hps_save falling: clear dirty, go to RELEASE.
- CLEAR:
  - Counter 0..2^AW-1; one write of CLEAR_VAL per cycle (ram_we = 1), 1024 cycles total.
  - After writing address 1023: set dirty, go to RELEASE.
  - The counter does not wrap-restart.
  - clear_req edges during CLEAR are ignored.
- RELEASE: cpu_pause = 0; wait for pause_ack = 0, then go to IDLE. busy stays high until IDLE.
- hps_wr/hps_rd outside LOAD/SAVE are dropped.
- An HPS address beyond 2^AW-1 is truncated to AW bits.
- Reset asserted mid-operation: immediate return to IDLE, pause released, partial clear abandoned.

Decomposition:
- Package williams2_nvram_pkg: state enum (IDLE, PAUSE, LOAD, SAVE, CLEAR, RELEASE), NV_AW, NV_DW, CLEAR_VAL.
- No sub-module; a single FSM plus clear counter and read pipeline.

Test Plan:
- CPU write addr 0x123 data 0xA in IDLE -> ram_we same cycle, ram_addr = 0x123, ram_din = 0xA; dirty rises next edge.
- hps_save high, pause_ack after 5 cycles, hps_rd addr 0x010 with RAM holding 0x5 -> hps_dout = 8'hF5 two cycles after the strobe; hps_wait high for exactly 2 cycles; on save end dirty = 0 and cpu_pause drops.
- hps_load with 1024 writes of 0x3C -> RAM holds 0xC everywhere; CPU writes during LOAD leave RAM unchanged.
- clear_req pulse -> exactly 1024 consecutive ram_we cycles, addresses 0..1023, data 0x0; busy spans PAUSE through RELEASE.
- hps_load and clear_req asserted in the same cycle -> LOAD served first, then CLEAR without a new edge.
- reset_n low at clear count 500 -> cpu_pause = 0, busy = 0, ram_we = 0 immediately; no further writes after reset release.
